l1c_axi_refill_bridge: RTL and testbench

//  Memory-side responder for the L1 cache miss interface (I_rreq/I_wreq/I_addr/I_wait/I_out).

---
 rtl/l1c_axi_refill_bridge_if.sv | 63 ++++++
 rtl/l1c_axi_refill_bridge.sv | 164 ++++++++++++++++
 tb/tb_l1c_axi_refill_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1c_axi_refill_bridge_if.sv
// AXI4 master-port signal bundle used by the L1 refill bridge.
// The bridge drives the master modport; the memory/interconnect model uses slave.
interface l1c_axi_refill_bridge_if;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/l1c_axi_refill_bridge.sv
// L1 cache miss responder: line refills become 4-beat INCR AXI reads replayed to the
// cache on consecutive cycles; single-word writes become 1-beat AXI writes with strobes.
module l1c_axi_refill_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_rreq,
    input  logic        I_wreq,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_in,
    input  logic [2:0]  I_type,
    output logic [31:0] I_out,
    output logic        I_wait,
    output logic        bus_err,
    l1c_axi_refill_bridge_if.master axi
);

    localparam logic [1:0] LastBeat = 2'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        StIdle, StAr, StRbuf, StStream, StWr, StWb, StWdone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] line_q [LINE_BEATS];
    logic [31:0] line_d [LINE_BEATS];
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bus_err_q, bus_err_d;
    logic        aw_now, w_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            for (int i = 0; i < int'(LINE_BEATS); i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            type_q    <= type_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bus_err_q <= bus_err_d;
            for (int i = 0; i < int'(LINE_BEATS); i++) line_q[i] <= line_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        type_d    = type_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bus_err_d = bus_err_q;
        for (int i = 0; i < int'(LINE_BEATS); i++) line_d[i] = line_q[i];
        aw_now    = aw_done_q | (axi.AWVALID & axi.AWREADY);
        w_now     = w_done_q | (axi.WVALID & axi.WREADY);

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (I_rreq) begin
                    state_d = StAr;
                    addr_d  = {I_addr[31:4], 4'h0};
                    // Cleared so words missing after an early RLAST replay as zero.
                    for (int i = 0; i < int'(LINE_BEATS); i++) line_d[i] = '0;
                end else if (I_wreq) begin
                    state_d   = StWr;
                    addr_d    = I_addr;
                    wdata_d   = I_in;
                    type_d    = I_type;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StAr: begin
                if (axi.ARREADY) state_d = StRbuf;
            end
            StRbuf: begin
                if (axi.RVALID) begin
                    line_d[cnt_q] = axi.RDATA;
                    if (axi.RRESP != 2'b00 || axi.RID != AXI_ID) bus_err_d = 1'b1;
                    if (axi.RLAST || cnt_q == LastBeat) begin
                        state_d = StStream;
                        cnt_d   = '0;
                        if (cnt_q != LastBeat) bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StStream: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LastBeat) state_d = StIdle;
            end
            StWr: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    state_d   = StWb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWb: begin
                if (axi.BVALID) begin
                    if (axi.BRESP != 2'b00 || axi.BID != AXI_ID) bus_err_d = 1'b1;
                    state_d = StWdone;
                end
            end
            StWdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        axi.WSTRB = 4'hF;
        unique case (type_q[1:0])
            2'b00:   axi.WSTRB = 4'b0001 << addr_q[1:0];
            2'b01:   axi.WSTRB = 4'b0011 << {addr_q[1], 1'b0};
            default: axi.WSTRB = 4'hF;
        endcase
    end

    assign I_wait  = !(state_q == StStream || state_q == StWdone);
    assign I_out   = (state_q == StStream) ? line_q[cnt_q] : 32'h0;
    assign bus_err = bus_err_q;

    assign axi.ARID    = AXI_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = 4'(LINE_BEATS - 1);
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (state_q == StAr);
    assign axi.RREADY  = (state_q == StRbuf);

    assign axi.AWID    = AXI_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 4'h0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = (state_q == StWr) && !aw_done_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = (state_q == StWr) && !w_done_q;
    assign axi.BREADY  = (state_q == StWb);

endmodule

// File: tb/tb_l1c_axi_refill_bridge.sv
// Directed bench for l1c_axi_refill_bridge: a vector table of reads/writes plus
// hand-written sequences for request priority, error responses and mid-burst reset.
module tb_l1c_axi_refill_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_rreq, I_wreq;
    logic [31:0] I_addr, I_in;
    logic [2:0]  I_type;
    logic [31:0] I_out;
    logic        I_wait, bus_err;
    int          checks = 0;
    int          errors = 0;

    l1c_axi_refill_bridge_if bus ();

    l1c_axi_refill_bridge #(.AXI_ID(4'h0), .LINE_BEATS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .I_rreq  (I_rreq),
        .I_wreq  (I_wreq),
        .I_addr  (I_addr),
        .I_in    (I_in),
        .I_type  (I_type),
        .I_out   (I_out),
        .I_wait  (I_wait),
        .bus_err (bus_err),
        .axi     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
        int          d0;    // ARREADY / AWREADY delay
        int          d1;    // R-beat gap / WREADY delay
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_wait"}, {31'd0, I_wait}, 32'd1);
        chk({tag, "_i_out"}, I_out, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({tag, "_valids"}, {28'd0, bus.ARVALID, bus.AWVALID, bus.WVALID, 1'b0}, 32'd0);
        chk({tag, "_readys"}, {30'd0, bus.RREADY, bus.BREADY}, 32'd0);
    endtask

    function automatic logic [31:0] rword(input logic [31:0] addr, input int i);
        return {16'hDA7A, addr[11:4], 8'(i)};
    endfunction

    // Full read: cache raises I_rreq, memory answers with nbeats beats, then 4 replay cycles.
    task automatic do_read(input logic [31:0] addr, input int ar_d, input int gap,
                           input int err_beat, input int nbeats);
        bit ok = 1'b0;
        I_rreq = 1'b1;
        I_addr = addr;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.ARVALID) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("arvalid_timeout", {31'd0, bus.ARVALID}, 32'd1);
            I_rreq = 1'b0;
            return;
        end
        chk("araddr", bus.ARADDR, {addr[31:4], 4'h0});
        chk("ar_static", {21'd0, bus.ARID, bus.ARLEN, bus.ARSIZE},
            {21'd0, 4'h0, 4'h3, 3'b010});
        chk("arburst", {30'd0, bus.ARBURST}, 32'd1);
        chk("awvalid_during_ar", {31'd0, bus.AWVALID}, 32'd0);
        for (int d = 0; d < ar_d; d++) begin
            @(negedge clk);
            chk("arvalid_hold", {31'd0, bus.ARVALID}, 32'd1);
        end
        bus.ARREADY = 1'b1;
        @(negedge clk);
        bus.ARREADY = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk("i_wait_gap", {31'd0, I_wait}, 32'd1);
                @(negedge clk);
            end
            chk("rready", {31'd0, bus.RREADY}, 32'd1);
            bus.RVALID = 1'b1;
            bus.RDATA  = rword(addr, b);
            bus.RLAST  = (b == nbeats - 1);
            bus.RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
            @(negedge clk);
            bus.RVALID = 1'b0;
            bus.RLAST  = 1'b0;
            bus.RRESP  = 2'b00;
        end
        for (int b = 0; b < 4; b++) begin
            chk("stream_i_wait", {31'd0, I_wait}, 32'd0);
            chk("stream_i_out", I_out, (b < nbeats) ? rword(addr, b) : 32'd0);
            if (b == 3) I_rreq = 1'b0;
            @(negedge clk);
        end
        chk("post_stream_i_wait", {31'd0, I_wait}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] typ, input logic [3:0] strb,
                            input int aw_d, input int w_d,
                            input logic [1:0] bresp, input logic [3:0] bid);
        bit ok = 1'b0;
        bit aw_hs = 1'b0;
        bit w_hs = 1'b0;
        bit aw_fire, w_fire;
        int c = 0;
        I_wreq = 1'b1;
        I_addr = addr;
        I_in   = data;
        I_type = typ;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.AWVALID) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("awvalid_timeout", {31'd0, bus.AWVALID}, 32'd1);
            I_wreq = 1'b0;
            return;
        end
        chk("awaddr", bus.AWADDR, addr);
        chk("wstrb", {28'd0, bus.WSTRB}, {28'd0, strb});
        chk("wdata", bus.WDATA, data);
        chk("aw_static", {20'd0, bus.AWID, bus.AWLEN, bus.AWSIZE, bus.WLAST},
            {20'd0, 4'h0, 4'h0, 3'b010, 1'b1});
        chk("awburst", {30'd0, bus.AWBURST}, 32'd1);
        while (!(aw_hs && w_hs) && c < 20) begin
            bus.AWREADY = (c >= aw_d);
            bus.WREADY  = (c >= w_d);
            chk("awvalid", {31'd0, bus.AWVALID}, {31'd0, !aw_hs});
            chk("wvalid", {31'd0, bus.WVALID}, {31'd0, !w_hs});
            aw_fire = bus.AWVALID && bus.AWREADY;
            w_fire  = bus.WVALID && bus.WREADY;
            @(negedge clk);
            aw_hs = aw_hs | aw_fire;
            w_hs  = w_hs | w_fire;
            c++;
        end
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        chk("bready", {31'd0, bus.BREADY}, 32'd1);
        chk("wb_i_wait", {31'd0, I_wait}, 32'd1);
        bus.BVALID = 1'b1;
        bus.BRESP  = bresp;
        bus.BID    = bid;
        @(negedge clk);
        bus.BVALID = 1'b0;
        bus.BRESP  = 2'b00;
        bus.BID    = 4'h0;
        chk("wdone_i_wait", {31'd0, I_wait}, 32'd0);
        chk("wdone_bready", {31'd0, bus.BREADY}, 32'd0);
        I_wreq = 1'b0;
        @(negedge clk);
        chk("post_write_i_wait", {31'd0, I_wait}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1230, 32'h0,         3'b010, 0, 0, 32'h0000_1230, 4'h0};
        vecs[1] = '{1'b0, 32'h4567_89AC, 32'h0,         3'b010, 3, 2, 32'h4567_89A0, 4'h0};
        vecs[2] = '{1'b1, 32'h0000_2003, 32'hAB00_0000, 3'b000, 0, 0, 32'h0000_2003, 4'b1000};
        vecs[3] = '{1'b1, 32'h0000_2002, 32'h1234_0000, 3'b001, 1, 1, 32'h0000_2002, 4'b1100};
        vecs[4] = '{1'b1, 32'h0000_2000, 32'h0000_5678, 3'b101, 0, 2, 32'h0000_2000, 4'b0011};
        vecs[5] = '{1'b1, 32'h0000_3000, 32'hCAFE_F00D, 3'b010, 2, 0, 32'h0000_3000, 4'b1111};
        vecs[6] = '{1'b1, 32'h0000_3001, 32'h0000_EE00, 3'b100, 0, 3, 32'h0000_3001, 4'b0010};

        rst = 1'b1;
        I_rreq = 1'b0; I_wreq = 1'b0; I_addr = '0; I_in = '0; I_type = '0;
        bus.ARREADY = 1'b0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0;
        bus.RLAST = 1'b0; bus.RVALID = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.BID = '0; bus.BRESP = '0; bus.BVALID = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].exp_addr, vecs[i].data, vecs[i].typ, vecs[i].exp_strb,
                         vecs[i].d0, vecs[i].d1, 2'b00, 4'h0);
            else
                do_read(vecs[i].addr, vecs[i].d0, vecs[i].d1, -1, 4);
        end
        chk("bus_err_clean", {31'd0, bus_err}, 32'd0);

        // Both requests together: read wins, write follows the replay.
        I_wreq = 1'b1;
        I_in   = 32'h0BAD_BEEF;
        I_type = 3'b010;
        do_read(32'h0000_5000, 0, 0, -1, 4);
        do_write(32'h0000_5000, 32'h0BAD_BEEF, 3'b010, 4'hF, 0, 0, 2'b00, 4'h0);

        // SLVERR on beat 2: sticky error, data still delivered.
        do_read(32'h0000_6000, 0, 1, 2, 4);
        chk("bus_err_rresp", {31'd0, bus_err}, 32'd1);
        do_write(32'h0000_6004, 32'h1111_2222, 3'b010, 4'hF, 0, 0, 2'b00, 4'h0);
        chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // Reset in the middle of RBUF after two beats.
        I_rreq = 1'b1;
        I_addr = 32'h0000_7000;
        @(negedge clk);
        chk("mid_arvalid", {31'd0, bus.ARVALID}, 32'd1);
        bus.ARREADY = 1'b1;
        @(negedge clk);
        bus.ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = 32'hDEAD_0000 + 32'(b);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        chk("mid_reset_rready_ignored", {31'd0, bus.RREADY}, 32'd0);
        @(negedge clk);
        bus.RVALID = 1'b0;
        rst    = 1'b0;
        I_rreq = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_mid_reset");
        do_read(32'h0000_7000, 1, 0, -1, 4);
        chk("bus_err_after_fresh", {31'd0, bus_err}, 32'd0);

        // Early RLAST after two beats: zeros fill the rest, error flagged.
        do_read(32'h0000_8000, 0, 0, -1, 2);
        chk("bus_err_early_rlast", {31'd0, bus_err}, 32'd1);

        // BID mismatch on a write.
        do_reset();
        chk("bus_err_cleared", {31'd0, bus_err}, 32'd0);
        do_write(32'h0000_9000, 32'h5555_AAAA, 3'b010, 4'hF, 0, 0, 2'b00, 4'h5);
        chk("bus_err_bid", {31'd0, bus_err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
